// File: rtl/conv_systolic_feeder_if.sv
// Feeder bus: tile/filter capture inputs and array lane outputs.
// Master drives the job request; slave is the feeder itself.
interface conv_systolic_feeder_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] i00, i01, i02, i03;
  logic [DATA_W-1:0] i10, i11, i12, i13;
  logic [DATA_W-1:0] i20, i21, i22, i23;
  logic [DATA_W-1:0] i30, i31, i32, i33;
  logic [DATA_W-1:0] f00, f01, f02;
  logic [DATA_W-1:0] f10, f11, f12;
  logic [DATA_W-1:0] f20, f21, f22;
  logic              mode;
  logic [DATA_W-1:0] a0, a1, a2;
  logic [DATA_W-1:0] b0, b1, b2;
  logic [2:0]        beat_idx;
  logic              beat_valid;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output i00, i01, i02, i03,
    output i10, i11, i12, i13,
    output i20, i21, i22, i23,
    output i30, i31, i32, i33,
    output f00, f01, f02,
    output f10, f11, f12,
    output f20, f21, f22,
    input  mode,
    input  a0, a1, a2,
    input  b0, b1, b2,
    input  beat_idx, beat_valid,
    input  busy, done
  );

  modport slave (
    input  start,
    input  i00, i01, i02, i03,
    input  i10, i11, i12, i13,
    input  i20, i21, i22, i23,
    input  i30, i31, i32, i33,
    input  f00, f01, f02,
    input  f10, f11, f12,
    input  f20, f21, f22,
    output mode,
    output a0, a1, a2,
    output b0, b1, b2,
    output beat_idx, beat_valid,
    output busy, done
  );
endinterface

// File: rtl/conv_systolic_feeder.sv
// Feeds a 3x3 weight-stationary array: weight preload on b lanes,
// then a row-banded, diagonally skewed 4x4 tile stream on a lanes.
module conv_systolic_feeder #(
  parameter int DATA_W       = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input logic clk_in,
  input logic rst,
  conv_systolic_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  typedef logic [DATA_W-1:0] pix_t;

  state_t state_q, state_nx;
  logic [3:0] cnt_q, cnt_nx;

  logic [3:0][3:0][DATA_W-1:0] tile_d, tile_q;
  logic [2:0][2:0][DATA_W-1:0] filt_d, filt_q, filt_src;

  logic                   mode_q, mode_nx;
  logic [2:0][DATA_W-1:0] a_q, a_nx;
  logic [2:0][DATA_W-1:0] b_q, b_nx;
  logic [2:0]             bidx_q, bidx_nx;
  logic                   bval_q, bval_nx;
  logic                   busy_q, busy_nx;
  logic                   done_q, done_nx;

  logic [1:0] wrow;
  logic [3:0] idx;

  assign tile_d[0] = {bus.i03, bus.i02, bus.i01, bus.i00};
  assign tile_d[1] = {bus.i13, bus.i12, bus.i11, bus.i10};
  assign tile_d[2] = {bus.i23, bus.i22, bus.i21, bus.i20};
  assign tile_d[3] = {bus.i33, bus.i32, bus.i31, bus.i30};
  assign filt_d[0] = {bus.f02, bus.f01, bus.f00};
  assign filt_d[1] = {bus.f12, bus.f11, bus.f10};
  assign filt_d[2] = {bus.f22, bus.f21, bus.f20};

  // State and step counter register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Next state and step sequencing
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nx = LOAD_W;
          cnt_nx   = '0;
        end
      end
      LOAD_W: begin
        if (cnt_q == 4'd2) begin
          state_nx = STREAM;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_q + 4'd1;
        end
      end
      STREAM: begin
        if (cnt_q == 4'd9) begin
          state_nx = (FLUSH_CYCLES == 0) ? DONE : FLUSH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_q + 4'd1;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'(FLUSH_CYCLES - 1)) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Lane values for the upcoming state; outputs are registered from these
  always_comb begin
    filt_src = (state_q == IDLE) ? filt_d : filt_q;
    mode_nx  = 1'b1;
    a_nx     = '0;
    b_nx     = '0;
    bidx_nx  = '0;
    bval_nx  = 1'b0;
    busy_nx  = (state_nx != IDLE);
    done_nx  = (state_nx == DONE);
    wrow     = 2'd2 - cnt_nx[1:0];
    idx      = '0;
    if (state_nx == LOAD_W) begin
      mode_nx = 1'b0;
      b_nx    = filt_src[wrow];
    end
    if (state_nx == STREAM) begin
      for (int r = 0; r < 3; r++) begin
        idx = cnt_nx - 4'(r);
        if (cnt_nx >= 4'(r) && idx <= 4'd7) begin
          a_nx[r] = tile_q[2'(r) + {1'b0, idx[2]}][idx[1:0]];
        end
      end
      if (cnt_nx <= 4'd7) begin
        bval_nx = 1'b1;
        bidx_nx = cnt_nx[2:0];
      end
    end
  end

  // Shadow capture of tile and filter on job acceptance
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tile_q <= '0;
      filt_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      tile_q <= tile_d;
      filt_q <= filt_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b1;
      a_q    <= '0;
      b_q    <= '0;
      bidx_q <= '0;
      bval_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mode_q <= mode_nx;
      a_q    <= a_nx;
      b_q    <= b_nx;
      bidx_q <= bidx_nx;
      bval_q <= bval_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
    end
  end

  assign bus.mode       = mode_q;
  assign bus.a0         = pix_t'(a_q[0]);
  assign bus.a1         = pix_t'(a_q[1]);
  assign bus.a2         = pix_t'(a_q[2]);
  assign bus.b0         = pix_t'(b_q[0]);
  assign bus.b1         = pix_t'(b_q[1]);
  assign bus.b2         = pix_t'(b_q[2]);
  assign bus.beat_idx   = bidx_q;
  assign bus.beat_valid = bval_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
